// File: rtl/rc4_decrypt_engine.sv
// RC4 PRGA decrypt phase: walks MSG_LEN encrypted ROM bytes against the key-scheduled S RAM,
// writes plaintext to decrypted RAM and aborts on the first non-printable byte.
module rc4_decrypt_engine #(
    parameter  int unsigned MSG_LEN = 32,
    localparam int unsigned KW      = ($clog2(MSG_LEN) < 1) ? 1 : $clog2(MSG_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Decrypt_Start,
    output logic          Decrypt_Finish,
    output logic          Decrypt_Valid,
    output logic [7:0]    s_addr,
    output logic [7:0]    s_data,
    output logic          s_wren,
    input  logic [7:0]    s_q,
    output logic [KW-1:0] enc_addr,
    input  logic [7:0]    enc_q,
    output logic [KW-1:0] dec_addr,
    output logic [7:0]    dec_data,
    output logic          dec_wren
);

    localparam logic [KW-1:0] K_LAST = KW'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_RD_I, ST_LD_I, ST_RD_J, ST_LD_J, ST_WR_I,
        ST_WR_J, ST_RD_F, ST_LD_F, ST_WR_OUT, ST_DONE
    } state_t;

    state_t        r_state, w_state_n;
    logic [7:0]    r_i, r_j, r_si, r_sj;
    logic [7:0]    w_i_n, w_j_n, w_si_n, w_sj_n;
    logic [KW-1:0] r_k, w_k_n;
    logic          r_ok, w_ok_n;
    logic          r_valid, w_valid_n;
    logic          r_finish, w_finish_n;
    logic [7:0]    r_s_addr, w_s_addr_n;
    logic [7:0]    r_s_data, w_s_data_n;
    logic          r_s_wren, w_s_wren_n;
    logic [KW-1:0] r_enc_addr, w_enc_addr_n;
    logic [KW-1:0] r_dec_addr, w_dec_addr_n;
    logic [7:0]    r_dec_data, w_dec_data_n;
    logic          r_dec_wren, w_dec_wren_n;
    logic          w_printable;

    // Byte under write in WR_OUT is lowercase a..z or space
    assign w_printable = ((r_dec_data >= 8'h61) && (r_dec_data <= 8'h7A)) || (r_dec_data == 8'h20);

    // Outputs are registered from the next state, so each value is present during its own state
    always_comb begin
        w_state_n    = r_state;
        w_i_n        = r_i;
        w_j_n        = r_j;
        w_si_n       = r_si;
        w_sj_n       = r_sj;
        w_k_n        = r_k;
        w_ok_n       = r_ok;
        w_valid_n    = r_valid;
        w_finish_n   = 1'b0;
        w_s_addr_n   = 8'd0;
        w_s_data_n   = 8'd0;
        w_s_wren_n   = 1'b0;
        w_enc_addr_n = '0;
        w_dec_addr_n = '0;
        w_dec_data_n = 8'd0;
        w_dec_wren_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Decrypt_Start) begin
                    w_state_n  = ST_RD_I;
                    w_i_n      = 8'd0;
                    w_j_n      = 8'd0;
                    w_k_n      = '0;
                    w_ok_n     = 1'b1;
                    w_valid_n  = 1'b0;
                    w_s_addr_n = 8'd1;
                end
            end
            ST_RD_I: begin
                w_state_n = ST_LD_I;
                w_i_n     = r_i + 8'd1;
            end
            ST_LD_I: begin
                w_state_n  = ST_RD_J;
                w_si_n     = s_q;
                w_j_n      = r_j + s_q;
                w_s_addr_n = r_j + s_q;
            end
            ST_RD_J: w_state_n = ST_LD_J;
            ST_LD_J: begin
                w_state_n  = ST_WR_I;
                w_sj_n     = s_q;
                w_s_addr_n = r_i;
                w_s_data_n = s_q;
                w_s_wren_n = 1'b1;
            end
            ST_WR_I: begin
                w_state_n    = ST_WR_J;
                w_s_addr_n   = r_j;
                w_s_data_n   = r_si;
                w_s_wren_n   = 1'b1;
                w_enc_addr_n = r_k;
            end
            ST_WR_J: begin
                w_state_n    = ST_RD_F;
                w_s_addr_n   = r_si + r_sj;
                w_enc_addr_n = r_k;
            end
            ST_RD_F: w_state_n = ST_LD_F;
            ST_LD_F: begin
                // s_q is the keystream byte, enc_q the ROM byte addressed during RD_F
                w_state_n    = ST_WR_OUT;
                w_dec_addr_n = r_k;
                w_dec_data_n = s_q ^ enc_q;
                w_dec_wren_n = 1'b1;
            end
            ST_WR_OUT: begin
                w_k_n = r_k + KW'(1);
                if (!w_printable) begin
                    w_state_n  = ST_DONE;
                    w_ok_n     = 1'b0;
                    w_valid_n  = 1'b0;
                    w_finish_n = 1'b1;
                end else if (r_k == K_LAST) begin
                    w_state_n  = ST_DONE;
                    w_valid_n  = r_ok;
                    w_finish_n = 1'b1;
                end else begin
                    w_state_n  = ST_RD_I;
                    w_s_addr_n = r_i + 8'd1;
                end
            end
            ST_DONE: w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_i        <= 8'd0;
            r_j        <= 8'd0;
            r_si       <= 8'd0;
            r_sj       <= 8'd0;
            r_k        <= '0;
            r_ok       <= 1'b0;
            r_valid    <= 1'b0;
            r_finish   <= 1'b0;
            r_s_addr   <= 8'd0;
            r_s_data   <= 8'd0;
            r_s_wren   <= 1'b0;
            r_enc_addr <= '0;
            r_dec_addr <= '0;
            r_dec_data <= 8'd0;
            r_dec_wren <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_i        <= w_i_n;
            r_j        <= w_j_n;
            r_si       <= w_si_n;
            r_sj       <= w_sj_n;
            r_k        <= w_k_n;
            r_ok       <= w_ok_n;
            r_valid    <= w_valid_n;
            r_finish   <= w_finish_n;
            r_s_addr   <= w_s_addr_n;
            r_s_data   <= w_s_data_n;
            r_s_wren   <= w_s_wren_n;
            r_enc_addr <= w_enc_addr_n;
            r_dec_addr <= w_dec_addr_n;
            r_dec_data <= w_dec_data_n;
            r_dec_wren <= w_dec_wren_n;
        end
    end

    assign Decrypt_Finish = r_finish;
    assign Decrypt_Valid  = r_valid;
    assign s_addr         = r_s_addr;
    assign s_data         = r_s_data;
    assign s_wren         = r_s_wren;
    assign enc_addr       = r_enc_addr;
    assign dec_addr       = r_dec_addr;
    assign dec_data       = r_dec_data;
    assign dec_wren       = r_dec_wren;

endmodule

// File: tb/tb_rc4_decrypt_engine.sv
// Bench for rc4_decrypt_engine: a 2-byte instance for directed vectors and corner sequences,
// a 32-byte instance for random permutations checked against a plain RC4 reference.
module tb_rc4_decrypt_engine;

    localparam int unsigned ML_A = 2;
    localparam int unsigned ML_B = 32;
    localparam int unsigned KW_A = 1;
    localparam int unsigned KW_B = 5;

    logic clk = 1'b0;
    logic rst;
    logic start_a, start_b;
    logic fin_a, fin_b, valid_a, valid_b;
    logic [7:0] s_addr_a, s_addr_b, s_data_a, s_data_b, s_q_a, s_q_b;
    logic s_wren_a, s_wren_b, dec_wren_a, dec_wren_b;
    logic [7:0] enc_q_a, enc_q_b, dec_data_a, dec_data_b;
    logic [KW_A-1:0] enc_addr_a, dec_addr_a;
    logic [KW_B-1:0] enc_addr_b, dec_addr_b;

    logic [7:0] s_mem_a[256], enc_mem_a[256], dec_mem_a[256];
    logic [7:0] s_mem_b[256], enc_mem_b[256], dec_mem_b[256];
    logic [7:0] img_s[256], img_enc[256];
    logic       ld_a = 1'b0, ld_b = 1'b0;
    int sw_a = 0, dw_a = 0, fc_a = 0, sw_b = 0, dw_b = 0, fc_b = 0;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_s[256], m_ks[256], m_dec[256];
    int         m_n;
    logic       m_ok;

    always #5 clk = ~clk;

    rc4_decrypt_engine #(.MSG_LEN(ML_A)) u_dut_a (
        .clk(clk), .rst(rst), .Decrypt_Start(start_a),
        .Decrypt_Finish(fin_a), .Decrypt_Valid(valid_a),
        .s_addr(s_addr_a), .s_data(s_data_a), .s_wren(s_wren_a), .s_q(s_q_a),
        .enc_addr(enc_addr_a), .enc_q(enc_q_a),
        .dec_addr(dec_addr_a), .dec_data(dec_data_a), .dec_wren(dec_wren_a)
    );

    rc4_decrypt_engine #(.MSG_LEN(ML_B)) u_dut_b (
        .clk(clk), .rst(rst), .Decrypt_Start(start_b),
        .Decrypt_Finish(fin_b), .Decrypt_Valid(valid_b),
        .s_addr(s_addr_b), .s_data(s_data_b), .s_wren(s_wren_b), .s_q(s_q_b),
        .enc_addr(enc_addr_b), .enc_q(enc_q_b),
        .dec_addr(dec_addr_b), .dec_data(dec_data_b), .dec_wren(dec_wren_b)
    );

    // Synchronous RAM/ROM models with one-cycle read latency; ld_* reloads from the images
    always @(posedge clk) begin
        s_q_a   <= s_mem_a[s_addr_a];
        enc_q_a <= enc_mem_a[8'(enc_addr_a)];
        if (ld_a) begin
            for (int x = 0; x < 256; x++) begin
                s_mem_a[x]   = img_s[x];
                enc_mem_a[x] = img_enc[x];
                dec_mem_a[x] = 8'hEE;
            end
            sw_a = 0; dw_a = 0; fc_a = 0;
        end else begin
            if (s_wren_a) begin s_mem_a[s_addr_a] = s_data_a; sw_a++; end
            if (dec_wren_a) begin dec_mem_a[8'(dec_addr_a)] = dec_data_a; dw_a++; end
            if (fin_a) fc_a++;
        end
    end

    always @(posedge clk) begin
        s_q_b   <= s_mem_b[s_addr_b];
        enc_q_b <= enc_mem_b[8'(enc_addr_b)];
        if (ld_b) begin
            for (int x = 0; x < 256; x++) begin
                s_mem_b[x]   = img_s[x];
                enc_mem_b[x] = img_enc[x];
                dec_mem_b[x] = 8'hEE;
            end
            sw_b = 0; dw_b = 0; fc_b = 0;
        end else begin
            if (s_wren_b) begin s_mem_b[s_addr_b] = s_data_b; sw_b++; end
            if (dec_wren_b) begin dec_mem_b[8'(dec_addr_b)] = dec_data_b; dw_b++; end
            if (fin_b) fc_b++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic printable(input logic [7:0] c);
        return (c == 8'h20) || ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    function automatic logic fin_of(input int u);
        return (u == 0) ? fin_a : fin_b;
    endfunction

    // Plain RC4 PRGA over img_s/img_enc; stops after the first non-printable byte when stop_en
    task automatic rc4_ref(input int ml, input logic stop_en);
        logic [7:0] i, j, t;
        for (int x = 0; x < 256; x++) m_s[x] = img_s[x];
        i = 8'd0; j = 8'd0; m_n = 0; m_ok = 1'b1;
        for (int b = 0; b < ml; b++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            m_ks[b]  = m_s[8'(m_s[i] + m_s[j])];
            m_dec[b] = m_ks[b] ^ img_enc[b];
            m_n = b + 1;
            if (stop_en && !printable(m_dec[b])) begin
                m_ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic load(input int u);
        @(negedge clk);
        if (u == 0) ld_a = 1'b1; else ld_b = 1'b1;
        @(negedge clk);
        ld_a = 1'b0; ld_b = 1'b0;
    endtask

    // Returns at the negedge of cycle t+1 (accept at edge t)
    task automatic pulse_start(input int u);
        @(negedge clk);
        if (u == 0) start_a = 1'b1; else start_b = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic run(input int u, input int limit, output int fcyc);
        pulse_start(u);
        fcyc = -1;
        for (int c = 1; c <= limit; c++) begin
            if (fin_of(u)) begin
                fcyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic void ident_image();
        for (int x = 0; x < 256; x++) begin
            img_s[x]   = 8'(x);
            img_enc[x] = 8'h00;
        end
    endfunction

    typedef struct {
        logic [7:0] enc0, enc1, dec0, dec1;
        logic       vld;
        int         fin, sw, dw;
        logic [7:0] s2, s3;
    } vec_t;

    vec_t vt[10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int fcyc, mism, p, snap_sw, snap_fc;
        logic bad;
        logic [7:0] pt[32];
        logic [7:0] v8;

        // Identity S gives keystream 8'h02, 8'h05 for the first two bytes
        vt[0] = '{8'h63, 8'h67, 8'h61, 8'h62, 1'b1, 19, 4, 2, 8'h03, 8'h02};
        vt[1] = '{8'h02, 8'h00, 8'h00, 8'hEE, 1'b0, 10, 2, 1, 8'h02, 8'h03};
        vt[2] = '{8'h22, 8'h25, 8'h20, 8'h20, 1'b1, 19, 4, 2, 8'h03, 8'h02};
        vt[3] = '{8'h78, 8'h7F, 8'h7A, 8'h7A, 1'b1, 19, 4, 2, 8'h03, 8'h02};
        vt[4] = '{8'h62, 8'h00, 8'h60, 8'hEE, 1'b0, 10, 2, 1, 8'h02, 8'h03};
        vt[5] = '{8'h79, 8'h00, 8'h7B, 8'hEE, 1'b0, 10, 2, 1, 8'h02, 8'h03};
        vt[6] = '{8'h63, 8'h65, 8'h61, 8'h60, 1'b0, 19, 4, 2, 8'h03, 8'h02};
        vt[7] = '{8'h63, 8'h7E, 8'h61, 8'h7B, 1'b0, 19, 4, 2, 8'h03, 8'h02};
        vt[8] = '{8'h23, 8'h00, 8'h21, 8'hEE, 1'b0, 10, 2, 1, 8'h02, 8'h03};
        vt[9] = '{8'h22, 8'h27, 8'h20, 8'h22, 1'b0, 19, 4, 2, 8'h03, 8'h02};

        // Reset held two cycles with start asserted
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_finish", 32'({fin_a, fin_b}), 32'd0);
        chk("rst_valid", 32'({valid_a, valid_b}), 32'd0);
        chk("rst_wren", 32'({s_wren_a, dec_wren_a, s_wren_b, dec_wren_b}), 32'd0);
        chk("rst_addr", 32'({s_addr_a, enc_addr_a, dec_addr_a, s_addr_b, enc_addr_b, dec_addr_b}), 32'd0);
        chk("rst_data", 32'({s_data_a, dec_data_a, s_data_b, dec_data_b}), 32'd0);
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (fin_a || s_wren_a || dec_wren_a || (s_addr_a != 8'd0) || (s_addr_b != 8'd0)) bad = 1'b1;
        end
        chk("rst_no_accept", 32'(bad), 32'd0);

        // Directed vectors on the 2-byte instance
        for (int v = 0; v < 10; v++) begin
            ident_image();
            img_enc[0] = vt[v].enc0;
            img_enc[1] = vt[v].enc1;
            load(0);
            run(0, 100, fcyc);
            chk($sformatf("tbl%0d_fin_cycle", v), 32'(fcyc), 32'(vt[v].fin));
            chk($sformatf("tbl%0d_valid", v), 32'(valid_a), 32'(vt[v].vld));
            @(negedge clk);
            chk($sformatf("tbl%0d_fin_width", v), 32'(fin_a), 32'd0);
            chk($sformatf("tbl%0d_dec0", v), 32'(dec_mem_a[0]), 32'(vt[v].dec0));
            chk($sformatf("tbl%0d_dec1", v), 32'(dec_mem_a[1]), 32'(vt[v].dec1));
            chk($sformatf("tbl%0d_s_writes", v), 32'(sw_a), 32'(vt[v].sw));
            chk($sformatf("tbl%0d_dec_writes", v), 32'(dw_a), 32'(vt[v].dw));
            chk($sformatf("tbl%0d_s2", v), 32'(s_mem_a[2]), 32'(vt[v].s2));
            chk($sformatf("tbl%0d_s3", v), 32'(s_mem_a[3]), 32'(vt[v].s3));
        end

        // Start re-pulsed mid-run and in the DONE cycle is ignored
        ident_image();
        img_enc[0] = 8'h63; img_enc[1] = 8'h67;
        load(0);
        pulse_start(0);
        fcyc = -1;
        for (int c = 1; c <= 50; c++) begin
            start_a = (c == 3) || (c == 19);
            if (fin_a && (fcyc < 0)) fcyc = c;
            @(negedge clk);
        end
        start_a = 1'b0;
        chk("repulse_fin_cycle", 32'(fcyc), 32'd19);
        chk("repulse_fin_count", 32'(fc_a), 32'd1);
        chk("repulse_dec_writes", 32'(dw_a), 32'd2);
        chk("repulse_valid_held", 32'(valid_a), 32'd1);

        // Back-to-back: the following abort run clears Valid at accept
        img_enc[0] = 8'h02;
        load(0);
        chk("b2b_valid_before", 32'(valid_a), 32'd1);
        pulse_start(0);
        chk("b2b_valid_cleared", 32'(valid_a), 32'd0);
        fcyc = -1;
        for (int c = 1; c <= 40; c++) begin
            if (fin_a) begin fcyc = c; break; end
            @(negedge clk);
        end
        chk("b2b_abort_fin_cycle", 32'(fcyc), 32'd10);
        chk("b2b_abort_valid", 32'(valid_a), 32'd0);
        @(negedge clk);
        chk("b2b_fin_width", 32'(fin_a), 32'd0);

        // Reset pulsed in WR_I of byte 0, then a clean rerun
        ident_image();
        img_enc[0] = 8'h63; img_enc[1] = 8'h67;
        load(0);
        pulse_start(0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_idle_outputs", 32'({s_wren_a, dec_wren_a, fin_a, s_addr_a}), 32'd0);
        snap_sw = sw_a;
        snap_fc = fc_a;
        repeat (25) @(negedge clk);
        chk("midrst_no_s_writes", 32'(sw_a), 32'(snap_sw));
        chk("midrst_no_dec_writes", 32'(dw_a), 32'd0);
        chk("midrst_no_finish", 32'(fc_a), 32'(snap_fc));
        run(0, 100, fcyc);
        chk("midrst_rerun_fin_cycle", 32'(fcyc), 32'd19);
        chk("midrst_rerun_valid", 32'(valid_a), 32'd1);
        chk("midrst_rerun_dec", 32'({dec_mem_a[0], dec_mem_a[1]}), 32'h6162);

        // Random permutations and plaintexts on the 32-byte instance
        for (int r = 0; r < 24; r++) begin
            for (int x = 0; x < 256; x++) begin
                img_s[x]   = 8'(x);
                img_enc[x] = 8'h00;
            end
            for (int x = 255; x > 0; x--) begin
                int y;
                y = int'($urandom_range(x, 0));
                v8 = img_s[x]; img_s[x] = img_s[y]; img_s[y] = v8;
            end
            rc4_ref(ML_B, 1'b0);
            for (int b = 0; b < 32; b++) begin
                p = int'($urandom_range(26, 0));
                pt[b] = (p == 26) ? 8'h20 : 8'(8'h61 + p);
            end
            if ((r % 2) == 1) begin
                p = (r == 1) ? 0 : (r == 3) ? 31 : int'($urandom_range(31, 0));
                do v8 = 8'($urandom); while (printable(v8));
                pt[p] = v8;
            end
            for (int b = 0; b < 32; b++) img_enc[b] = pt[b] ^ m_ks[b];
            rc4_ref(ML_B, 1'b1);
            load(1);
            run(1, 400, fcyc);
            chk($sformatf("rnd%0d_fin_cycle", r), 32'(fcyc), 32'(9 * m_n + 1));
            chk($sformatf("rnd%0d_valid", r), 32'(valid_b), 32'(m_ok));
            @(negedge clk);
            chk($sformatf("rnd%0d_fin_width", r), 32'(fin_b), 32'd0);
            chk($sformatf("rnd%0d_s_writes", r), 32'(sw_b), 32'(2 * m_n));
            chk($sformatf("rnd%0d_dec_writes", r), 32'(dw_b), 32'(m_n));
            mism = 0;
            for (int b = 0; b < 32; b++)
                if (dec_mem_b[b] !== ((b < m_n) ? m_dec[b] : 8'hEE)) mism++;
            chk($sformatf("rnd%0d_dec_bytes_bad", r), 32'(mism), 32'd0);
            mism = 0;
            for (int x = 0; x < 256; x++)
                if (s_mem_b[x] !== m_s[x]) mism++;
            chk($sformatf("rnd%0d_s_ram_bad", r), 32'(mism), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
